// File: rtl/reg_bank_write_arbiter_if.sv
// Bus bundle for the two-requester register bank write arbiter.
// The master side is the producer/reader; the slave side is the arbiter itself.
interface reg_bank_write_arbiter_if #(
  parameter int N      = 4,
  parameter int ADDR_W = 2
);
  // Requester 0 write channel
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [N-1:0]      req0_data;
  logic              req0_ready;

  // Requester 1 write channel
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [N-1:0]      req1_data;
  logic              req1_ready;

  // Combinational read port
  logic [ADDR_W-1:0] rd_addr;
  logic [N-1:0]      rd_data;

  // Registered trace of the last committed write, plus arbiter state
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [N-1:0]      wr_data;
  logic              prio;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output rd_addr,
    input  req0_ready, req1_ready,
    input  rd_data,
    input  wr_en, wr_addr, wr_data, prio
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  rd_addr,
    output req0_ready, req1_ready,
    output rd_data,
    output wr_en, wr_addr, wr_data, prio
  );
endinterface

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin arbiter sharing the write port of a small register bank between
// two valid/ready requesters. One combinational read port; every committed
// write is echoed on wr_en/wr_addr/wr_data one cycle later for tracing.
module reg_bank_write_arbiter #(
  parameter int N      = 4,
  parameter int ADDR_W = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  reg_bank_write_arbiter_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [N-1:0]      sel_data;

  logic              prio_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [N-1:0]      wr_data_reg;

  logic [N-1:0]      bank_word [DEPTH];

  // Grant selection: a lone requester always wins; under contention prio
  // picks the winner. Reset gates both grants so nothing is accepted while
  // rst_n is low, even though the flops are already cleared.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      if (bus.req0_valid && (!bus.req1_valid || !prio_reg)) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
    end
    xfer     = grant0 | grant1;
    sel_addr = grant1 ? bus.req1_addr : bus.req0_addr;
    sel_data = grant1 ? bus.req1_data : bus.req0_data;
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // One register per bank word; each loads only when the winning write targets it.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [N-1:0] word_reg;

      // Word gi: clear on reset, capture the granted data on a matching transfer.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_reg <= '0;
        end else if (xfer && (sel_addr == ADDR_W'(gi))) begin
          word_reg <= sel_data;
        end
      end

      assign bank_word[gi] = word_reg;
    end
  endgenerate

  // Read port is a plain mux, so a same-address write shows up only after the edge.
  assign bus.rd_data = bank_word[bus.rd_addr];

  // Priority flips away from whoever just won; the trace records each committed
  // write and keeps the last address/data when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_reg    <= 1'b0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= xfer;
      if (xfer) begin
        prio_reg    <= grant0;
        wr_addr_reg <= sel_addr;
        wr_data_reg <= sel_data;
      end
    end
  end

  assign bus.prio    = prio_reg;
  assign bus.wr_en   = wr_en_reg;
  assign bus.wr_addr = wr_addr_reg;
  assign bus.wr_data = wr_data_reg;
endmodule
